// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: bundles the reader's command, RAM read port and
// stream output. master = the reader, slave = its environment (command
// source, RAM, consumer). With RSR_CHECKSUM_EN defined a checksum output is added.
interface ram_stream_reader_if #(
  parameter int DW = 8,
  parameter int m  = 2
);
  // command side
  logic          start;
  logic [m-1:0]  base_addr;
  logic [m:0]    length;
  // RAM read port (combinational read of ram_addr)
  logic [m-1:0]  ram_addr;
  logic [DW-1:0] ram_rdata;
  // stream output
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  // status
  logic          busy;
  logic          done;
`ifdef RSR_CHECKSUM_EN
  logic [DW-1:0] checksum;

  modport master (
    input  start, base_addr, length, ram_rdata, out_ready,
    output ram_addr, out_data, out_valid, busy, done, checksum
  );
  modport slave (
    output start, base_addr, length, ram_rdata, out_ready,
    input  ram_addr, out_data, out_valid, busy, done, checksum
  );
`else
  modport master (
    input  start, base_addr, length, ram_rdata, out_ready,
    output ram_addr, out_data, out_valid, busy, done
  );
  modport slave (
    output start, base_addr, length, ram_rdata, out_ready,
    input  ram_addr, out_data, out_valid, busy, done
  );
`endif
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a range of an async-read RAM and streams each word
// out on a valid/ready port; one beat per 2 cycles, first valid 2 cycles after start.
// Ports: clk, rst (async active-high), bus (ram_stream_reader_if.master):
//   start/base_addr/length command, ram_addr/ram_rdata RAM read port,
//   out_data/out_valid/out_ready stream, busy/done status.
// Optional: define RSR_CHECKSUM_EN to add bus.checksum, the XOR of all
// delivered beats, cleared on every accepted start.
module ram_stream_reader #(
  parameter int DW = 8,
  parameter int m  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t        state, state_nxt;
  logic [m-1:0]  addr_q, addr_nxt;
  logic [m:0]    remaining_q, remaining_nxt;
  logic [DW-1:0] data_q, data_nxt;
  logic          valid_q, valid_nxt;
`ifdef RSR_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
`ifdef RSR_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      remaining_q <= remaining_nxt;
      data_q      <= data_nxt;
      valid_q     <= valid_nxt;
`ifdef RSR_CHECKSUM_EN
      csum_q      <= csum_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_q;
    remaining_nxt = remaining_q;
    data_nxt      = data_q;
    valid_nxt     = valid_q;
`ifdef RSR_CHECKSUM_EN
    csum_nxt      = csum_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef RSR_CHECKSUM_EN
          csum_nxt = '0;
`endif
          if (bus.length != '0) begin
            addr_nxt      = bus.base_addr;
            remaining_nxt = bus.length;
            state_nxt     = FETCH;
          end else begin
            // zero-length request: no beats, just the done pulse
            state_nxt = DONE;
          end
        end
      end
      FETCH: begin
        // ram_addr settled last cycle, so the async read data is valid now
        data_nxt  = bus.ram_rdata;
        valid_nxt = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (bus.out_ready) begin
          valid_nxt = 1'b0;
`ifdef RSR_CHECKSUM_EN
          csum_nxt  = csum_q ^ data_q;
`endif
          if (remaining_q == (m+1)'(1)) begin
            state_nxt = DONE;
          end else begin
            // m-bit add wraps the last location back to 0
            addr_nxt      = addr_q + m'(1);
            remaining_nxt = remaining_q - (m+1)'(1);
            state_nxt     = FETCH;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ram_addr  = addr_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
`ifdef RSR_CHECKSUM_EN
  assign bus.checksum  = csum_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bench for ram_stream_reader with a
// 4-word RAM model and a scoreboard queue of expected beats.
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int M  = 2;

  logic clk;
  logic rst;
  logic [DW-1:0] mem [4];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [DW-1:0] exp_q [$];

  ram_stream_reader_if #(.DW(DW), .m(M)) bus ();

  ram_stream_reader #(.DW(DW), .m(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // asynchronous-read RAM model
  assign bus.ram_rdata = mem[bus.ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // monitor: handshakes are seen at the negedge before the edge that takes them
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) done_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0)
          check("unexpected_beat", {24'h0, bus.out_data}, 32'hDEAD);
        else
          check("beat_data", {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // start pulse; returns 1 time unit after the edge that accepts it
  task automatic pulse_start(input int base, input int len);
    @(posedge clk); #1;
    bus.base_addr = M'(base);
    bus.length    = (M+1)'(len);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.done && cycles < budget);
    check("done_seen", {31'h0, bus.done}, 32'h1);
  endtask

  // called at the done negedge
  task automatic end_of_xfer(input string tag, input logic [DW-1:0] exp_csum);
    check({tag, "_busy_at_done"}, {31'h0, bus.busy}, 32'h1);
`ifdef RSR_CHECKSUM_EN
    check({tag, "_checksum"}, {24'h0, bus.checksum}, {24'h0, exp_csum});
`else
    if (exp_csum != exp_csum) check({tag, "_unused"}, 32'h0, 32'h0);
`endif
    @(negedge clk);
    check({tag, "_done_fall"}, {31'h0, bus.done}, 32'h0);
    check({tag, "_busy_fall"}, {31'h0, bus.busy}, 32'h0);
    check({tag, "_valid_idle"}, {31'h0, bus.out_valid}, 32'h0);
    check({tag, "_done_count"}, done_cnt, 32'd1);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_addr", {30'h0, bus.ram_addr}, 32'h0);
    check("rst_data", {24'h0, bus.out_data}, 32'h0);
`ifdef RSR_CHECKSUM_EN
    check("rst_checksum", {24'h0, bus.checksum}, 32'h0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // base=1, length=2: latency and data
    done_cnt = 0;
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    pulse_start(1, 2);
    @(negedge clk);
    check("t1_busy_fetch", {31'h0, bus.busy}, 32'h1);
    check("t1_valid_fetch", {31'h0, bus.out_valid}, 32'h0);
    check("t1_addr_fetch", {30'h0, bus.ram_addr}, 32'h1);
    @(negedge clk);
    check("t1_valid_first", {31'h0, bus.out_valid}, 32'h1);
    wait_done(40, cyc);
    end_of_xfer("t1", 8'h11);

    // base=3, length=3: wraps 3 -> 0, one beat per 2 cycles
    done_cnt = 0;
    exp_q.push_back(8'h44); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    pulse_start(3, 3);
    wait_done(40, cyc);
    check("t2_cycles", cyc, 32'd7);
    check("t2_addr_hold", {30'h0, bus.ram_addr}, 32'h1);
    end_of_xfer("t2", 8'h77);

    // zero length: done one cycle after start, no beats, address untouched
    done_cnt = 0;
    pulse_start(2, 0);
    wait_done(10, cyc);
    check("t3_cycles", cyc, 32'd1);
    check("t3_addr_hold", {30'h0, bus.ram_addr}, 32'h1);
    end_of_xfer("t3", 8'h00);

    // full range with a 5-cycle stall and an ignored second start
    done_cnt = 0;
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    pulse_start(0, 4);
    @(negedge clk);
    @(negedge clk);
    check("t4_valid_first", {31'h0, bus.out_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.start     = (i == 1);
      bus.base_addr = 2'd3;
      bus.length    = 3'd1;
      @(negedge clk);
      check("t4_stall_valid", {31'h0, bus.out_valid}, 32'h1);
      check("t4_stall_data", {24'h0, bus.out_data}, 32'h11);
      check("t4_stall_addr", {30'h0, bus.ram_addr}, 32'h0);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    wait_done(60, cyc);
    check("t4_addr_end", {30'h0, bus.ram_addr}, 32'h3);
    end_of_xfer("t4", 8'h44);

    // reset while the 2nd beat waits in SEND
    done_cnt = 0;
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h11);
    pulse_start(0, 4);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_second_valid", {31'h0, bus.out_valid}, 32'h1);
    check("t5_second_data", {24'h0, bus.out_data}, 32'h22);
    check("t5_second_addr", {30'h0, bus.ram_addr}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'h0, bus.out_valid}, 32'h0);
    check("t5_rst_busy", {31'h0, bus.busy}, 32'h0);
    check("t5_rst_done", {31'h0, bus.done}, 32'h0);
    check("t5_rst_addr", {30'h0, bus.ram_addr}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_done", done_cnt, 32'd0);
    check("t5_queue_empty", exp_q.size(), 32'd0);

    // normal operation after reset
    bus.out_ready = 1'b1;
    exp_q.push_back(8'h33);
    pulse_start(2, 1);
    wait_done(20, cyc);
    check("t6_cycles", cyc, 32'd3);
    end_of_xfer("t6", 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
